// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder: shared word-wide backing store for the LC-3b IF (read-only) and MEM
// (read/write) ports. Each accepted request takes LATENCY cycles to complete. Completion is a
// one-cycle resp pulse on the granted port.
// Optional build macro: MEMRESP_RR_ARB_EN selects round-robin arbitration on ties. Without it,
// MEM has fixed priority over IF.
module lc3b_mem_responder #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] if_memaddr,
  input  logic        if_memread,
  input  logic [1:0]  if_mem_byte_enable,
  output logic        if_mem_resp,
  output logic [15:0] if_mem_rdata,
  input  logic [15:0] mem_memaddr,
  input  logic        mem_memread,
  input  logic        mem_memwrite,
  input  logic [15:0] mem_mem_wdata,
  input  logic [1:0]  mem_mem_byte_enable,
  output logic        mem_mem_resp,
  output logic [15:0] mem_mem_rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam bit          Lat1  = (LATENCY == 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [3:0]          r_count;
  logic                r_grant_mem;
  logic                r_op_wr;
  logic [ADDR_W-1:0]   r_idx;
  logic [15:0]         r_wdata;
  logic [1:0]          r_be;
  logic [15:0]         r_if_rdata;
  logic [15:0]         r_mem_rdata;
  logic [15:0]         r_store [Depth];

  logic                w_req_if;
  logic                w_req_mem;
  logic                w_req_any;
  logic                w_pick_mem;
  logic                w_accept;
  logic                w_access;
  logic                w_acc_mem;
  logic                w_acc_wr;
  logic [ADDR_W-1:0]   w_acc_idx;
  logic [15:0]         w_acc_wdata;
  logic [1:0]          w_acc_be;
  logic [ADDR_W-1:0]   w_if_idx;
  logic [ADDR_W-1:0]   w_mem_idx;
  logic                w_unused_bits;

  assign w_req_if  = if_memread;
  assign w_req_mem = mem_memread | mem_memwrite;
  assign w_req_any = w_req_if | w_req_mem;
  assign w_accept  = (r_state == StIdle) && w_req_any;
  assign w_if_idx  = if_memaddr[ADDR_W:1];
  assign w_mem_idx = mem_memaddr[ADDR_W:1];

  // Byte-offset bit, aliased upper address bits and IF byte enables are intentionally ignored.
  assign w_unused_bits = ^{if_memaddr, mem_memaddr, if_mem_byte_enable};

`ifdef MEMRESP_RR_ARB_EN
  logic r_last_mem;

  // Remember the port granted on the most recent acceptance for tie-breaking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_mem <= 1'b0;
    end else if (w_accept) begin
      r_last_mem <= w_pick_mem;
    end
  end

  assign w_pick_mem = (w_req_if && w_req_mem) ? ~r_last_mem : w_req_mem;
`else
  assign w_pick_mem = w_req_mem;
`endif

  // Access strobe: edge into StResp. From StIdle only when LATENCY is 1.
  always_comb begin
    w_access = 1'b0;
    if (r_state == StIdle) begin
      w_access = w_req_any && Lat1;
    end else if (r_state == StBusy) begin
      w_access = (r_count == 4'd1);
    end
  end

  // Access operands: live inputs on a same-edge accept, latched copies otherwise.
  always_comb begin
    if (r_state == StIdle) begin
      w_acc_mem   = w_pick_mem;
      w_acc_wr    = w_pick_mem & mem_memwrite;
      w_acc_idx   = w_pick_mem ? w_mem_idx : w_if_idx;
      w_acc_wdata = mem_mem_wdata;
      w_acc_be    = mem_mem_byte_enable;
    end else begin
      w_acc_mem   = r_grant_mem;
      w_acc_wr    = r_op_wr;
      w_acc_idx   = r_idx;
      w_acc_wdata = r_wdata;
      w_acc_be    = r_be;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_req_any) begin
          w_state_next = Lat1 ? StResp : StBusy;
        end
      end
      StBusy: begin
        if (r_count == 4'd1) begin
          w_state_next = StResp;
        end
      end
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: resp pulse on the granted port only.
  always_comb begin
    if_mem_resp  = 1'b0;
    mem_mem_resp = 1'b0;
    if (r_state == StResp) begin
      if_mem_resp  = ~r_grant_mem;
      mem_mem_resp = r_grant_mem;
    end
  end

  // Request latch, latency counter and per-port read data registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count     <= 4'd0;
      r_grant_mem <= 1'b0;
      r_op_wr     <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= 16'h0000;
      r_be        <= 2'b00;
      r_if_rdata  <= 16'h0000;
      r_mem_rdata <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_count     <= 4'(LATENCY - 1);
        r_grant_mem <= w_pick_mem;
        r_op_wr     <= w_pick_mem & mem_memwrite;
        r_idx       <= w_pick_mem ? w_mem_idx : w_if_idx;
        r_wdata     <= mem_mem_wdata;
        r_be        <= mem_mem_byte_enable;
      end else if (r_state == StBusy) begin
        r_count <= r_count - 4'd1;
      end
      if (w_access && !w_acc_wr) begin
        if (w_acc_mem) begin
          r_mem_rdata <= r_store[w_acc_idx];
        end else begin
          r_if_rdata <= r_store[w_acc_idx];
        end
      end
    end
  end

  // Backing store: byte-enabled write; reset suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (reset_n && w_access && w_acc_wr) begin
      if (w_acc_be[0]) begin
        r_store[w_acc_idx][7:0] <= w_acc_wdata[7:0];
      end
      if (w_acc_be[1]) begin
        r_store[w_acc_idx][15:8] <= w_acc_wdata[15:8];
      end
    end
  end

  assign if_mem_rdata  = r_if_rdata;
  assign mem_mem_rdata = r_mem_rdata;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Self-checking bench for lc3b_mem_responder: vector table, hand-written corner sequences,
// then randomized transactions checked against a transaction-level reference model.
module tb_lc3b_mem_responder;

  localparam int LAT = 3;

  logic        clk;
  logic        reset_n;
  logic [15:0] if_memaddr;
  logic        if_memread;
  logic [1:0]  if_mem_byte_enable;
  logic        if_mem_resp;
  logic [15:0] if_mem_rdata;
  logic [15:0] mem_memaddr;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [15:0] mem_mem_wdata;
  logic [1:0]  mem_mem_byte_enable;
  logic        mem_mem_resp;
  logic [15:0] mem_mem_rdata;

  logic [15:0] l1_if_memaddr;
  logic        l1_if_memread;
  logic        l1_if_mem_resp;
  logic [15:0] l1_if_mem_rdata;
  logic [15:0] l1_mem_memaddr;
  logic        l1_mem_memread;
  logic        l1_mem_memwrite;
  logic [15:0] l1_mem_mem_wdata;
  logic [1:0]  l1_mem_mem_byte_enable;
  logic        l1_mem_mem_resp;
  logic [15:0] l1_mem_mem_rdata;

  lc3b_mem_responder #(.ADDR_W(12), .LATENCY(LAT)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .if_memaddr          (if_memaddr),
    .if_memread          (if_memread),
    .if_mem_byte_enable  (if_mem_byte_enable),
    .if_mem_resp         (if_mem_resp),
    .if_mem_rdata        (if_mem_rdata),
    .mem_memaddr         (mem_memaddr),
    .mem_memread         (mem_memread),
    .mem_memwrite        (mem_memwrite),
    .mem_mem_wdata       (mem_mem_wdata),
    .mem_mem_byte_enable (mem_mem_byte_enable),
    .mem_mem_resp        (mem_mem_resp),
    .mem_mem_rdata       (mem_mem_rdata)
  );

  lc3b_mem_responder #(.ADDR_W(12), .LATENCY(1)) dut1 (
    .clk                 (clk),
    .reset_n             (reset_n),
    .if_memaddr          (l1_if_memaddr),
    .if_memread          (l1_if_memread),
    .if_mem_byte_enable  (2'b11),
    .if_mem_resp         (l1_if_mem_resp),
    .if_mem_rdata        (l1_if_mem_rdata),
    .mem_memaddr         (l1_mem_memaddr),
    .mem_memread         (l1_mem_memread),
    .mem_memwrite        (l1_mem_memwrite),
    .mem_mem_wdata       (l1_mem_mem_wdata),
    .mem_mem_byte_enable (l1_mem_mem_byte_enable),
    .mem_mem_resp        (l1_mem_mem_resp),
    .mem_mem_rdata       (l1_mem_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  // Reference model: word store, expected rdata registers, last granted port.
  logic [15:0] m_mem [4096];
  logic [15:0] exp_if_rd;
  logic [15:0] exp_mem_rd;
  bit          m_last_mem;

  typedef struct {
    bit          rif;
    bit          mrd;
    bit          mwr;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [1:0]  be;
    bit          chk;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int unsigned widx(input logic [15:0] a);
    return int'(a[12:1]);
  endfunction

  // Random address whose word index stays within the pre-initialised words 0..31.
  function automatic logic [15:0] raddr();
    logic [15:0] a;
    a = 16'($urandom);
    a[12:6] = 7'd0;
    return a;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be);
    if (be[0]) m_mem[widx(a)][7:0] = wd[7:0];
    if (be[1]) m_mem[widx(a)][15:8] = wd[15:8];
  endtask

  // One transaction on the LATENCY=3 instance; requests held until their own resp.
  task automatic run_txn(input bit rif, input bit mrd, input bit mwr, input logic [15:0] aif,
                         input logic [15:0] amem, input logic [15:0] wd, input logic [1:0] be);
    int t_if;
    int t_mem;
    bit mem_first;
    bit mreq;
    mreq  = mrd | mwr;
    t_if  = -1;
    t_mem = -1;
    if (rif && mreq) begin
`ifdef MEMRESP_RR_ARB_EN
      mem_first = ~m_last_mem;
`else
      mem_first = 1'b1;
`endif
      t_mem      = mem_first ? LAT : 2 * LAT + 1;
      t_if       = mem_first ? 2 * LAT + 1 : LAT;
      m_last_mem = ~mem_first;
    end else if (rif) begin
      t_if       = LAT;
      m_last_mem = 1'b0;
    end else if (mreq) begin
      t_mem      = LAT;
      m_last_mem = 1'b1;
    end
    if_memread          = rif;
    if_memaddr          = aif;
    if_mem_byte_enable  = 2'($urandom);
    mem_memread         = mrd;
    mem_memwrite        = mwr;
    mem_memaddr         = amem;
    mem_mem_wdata       = wd;
    mem_mem_byte_enable = be;
    for (int k = 1; k <= 2 * LAT + 3; k++) begin
      @(negedge clk);
      if (k == t_mem) begin
        if (mwr) model_write(amem, wd, be);
        else exp_mem_rd = m_mem[widx(amem)];
      end
      if (k == t_if) exp_if_rd = m_mem[widx(aif)];
      chk($sformatf("resp k=%0d", k), {14'd0, if_mem_resp, mem_mem_resp},
          {14'd0, k == t_if, k == t_mem});
      chk($sformatf("if_rdata k=%0d", k), if_mem_rdata, exp_if_rd);
      chk($sformatf("mem_rdata k=%0d", k), mem_mem_rdata, exp_mem_rd);
      if (k == t_if) if_memread = 1'b0;
      if (k == t_mem) begin
        mem_memread  = 1'b0;
        mem_memwrite = 1'b0;
      end
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    vt[0]  = '{0, 0, 1, 16'h0010, 16'hBEEF, 2'b11, 0, 16'h0000};
    vt[1]  = '{1, 0, 0, 16'h0010, 16'h0000, 2'b00, 1, 16'hBEEF};
    vt[2]  = '{0, 0, 1, 16'h0020, 16'h1234, 2'b11, 0, 16'h0000};
    vt[3]  = '{0, 0, 1, 16'h0020, 16'hAB00, 2'b10, 0, 16'h0000};
    vt[4]  = '{0, 1, 0, 16'h0021, 16'h0000, 2'b00, 1, 16'hAB34};
    vt[5]  = '{0, 0, 1, 16'h0021, 16'hFFFF, 2'b00, 0, 16'h0000};
    vt[6]  = '{1, 0, 0, 16'h0020, 16'h0000, 2'b00, 1, 16'hAB34};
    vt[7]  = '{0, 1, 1, 16'h0010, 16'h00CD, 2'b01, 1, 16'hAB34};
    vt[8]  = '{0, 1, 0, 16'h2010, 16'h0000, 2'b00, 1, 16'hBECD};
    vt[9]  = '{0, 0, 1, 16'h0030, 16'h5555, 2'b11, 0, 16'h0000};
    vt[10] = '{1, 0, 0, 16'hE031, 16'h0000, 2'b00, 1, 16'h5555};

    reset_n = 1'b0;
    if_memaddr = 16'h0; if_memread = 1'b0; if_mem_byte_enable = 2'b00;
    mem_memaddr = 16'h0; mem_memread = 1'b0; mem_memwrite = 1'b0;
    mem_mem_wdata = 16'h0; mem_mem_byte_enable = 2'b00;
    l1_if_memaddr = 16'h0; l1_if_memread = 1'b0;
    l1_mem_memaddr = 16'h0; l1_mem_memread = 1'b0; l1_mem_memwrite = 1'b0;
    l1_mem_mem_wdata = 16'h0; l1_mem_mem_byte_enable = 2'b00;
    exp_if_rd = 16'h0000; exp_mem_rd = 16'h0000; m_last_mem = 1'b0;

    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("reset resp", {14'd0, if_mem_resp, mem_mem_resp}, 16'd0);
      chk("reset if_rdata", if_mem_rdata, 16'h0000);
      chk("reset mem_rdata", mem_mem_rdata, 16'h0000);
      chk("reset l1 resp", {14'd0, l1_if_mem_resp, l1_mem_mem_resp}, 16'd0);
    end

    for (int i = 0; i < 11; i++) begin
      run_txn(vt[i].rif, vt[i].mrd, vt[i].mwr, vt[i].addr, vt[i].addr, vt[i].wd, vt[i].be);
      if (vt[i].chk) begin
        chk($sformatf("vec%0d rdata", i), vt[i].rif ? if_mem_rdata : mem_mem_rdata, vt[i].exp);
      end
    end

    // Fill words 0..31 so random reads are defined.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] w;
      w = 5'(i);
      run_txn(0, 0, 1, 16'h0, {10'd0, w, 1'b0}, 16'($urandom), 2'b11);
    end

    // Ties: both ports raised together, held until resp.
    run_txn(1, 1, 0, 16'h0010, 16'h0020, 16'h0, 2'b00);
    run_txn(1, 0, 1, 16'h0022, 16'h0022, 16'h7E7E, 2'b11);

    // MEM read withdrawn after one cycle; inputs changed during BUSY are ignored.
    mem_memread = 1'b1;
    mem_memaddr = 16'h0020;
    m_last_mem  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) exp_mem_rd = m_mem[widx(16'h0020)];
      chk($sformatf("withdraw resp k=%0d", k), {14'd0, if_mem_resp, mem_mem_resp},
          {14'd0, 1'b0, k == 3});
      chk($sformatf("withdraw mem_rdata k=%0d", k), mem_mem_rdata, exp_mem_rd);
      if (k == 1) begin
        mem_memread = 1'b0;
        mem_memaddr = 16'h0030;
      end
    end

    // Reset during BUSY of a write: abandoned, store keeps old value.
    run_txn(0, 0, 1, 16'h0, 16'h0030, 16'h5555, 2'b11);
    mem_memwrite = 1'b1;
    mem_memaddr = 16'h0030;
    mem_mem_wdata = 16'hAAAA;
    mem_mem_byte_enable = 2'b11;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    mem_memwrite = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_if_rd = 16'h0000;
    exp_mem_rd = 16'h0000;
    m_last_mem = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("midreset resp k=%0d", k), {14'd0, if_mem_resp, mem_mem_resp}, 16'd0);
      chk("midreset mem_rdata", mem_mem_rdata, 16'h0000);
    end
    run_txn(0, 1, 0, 16'h0, 16'h0030, 16'h0, 2'b00);
    chk("midreset old value", mem_mem_rdata, 16'h5555);

    // Randomized traffic.
    for (int i = 0; i < 120; i++) begin
      int mode;
      int mop;
      bit rif;
      bit mreq;
      mode = int'($urandom_range(0, 2));
      mop  = int'($urandom_range(0, 2));
      rif  = (mode != 1);
      mreq = (mode != 0);
      run_txn(rif, mreq && (mop != 1), mreq && (mop != 0), raddr(), raddr(),
              16'($urandom), 2'($urandom));
    end

    // LATENCY=1 instance: write then read, resp one cycle after sampling.
    l1_mem_memwrite = 1'b1;
    l1_mem_memaddr = 16'h0010;
    l1_mem_mem_wdata = 16'hBEEF;
    l1_mem_mem_byte_enable = 2'b11;
    @(negedge clk);
    chk("l1 write resp", {14'd0, l1_if_mem_resp, l1_mem_mem_resp}, 16'd1);
    l1_mem_memwrite = 1'b0;
    @(negedge clk);
    chk("l1 write idle", {14'd0, l1_if_mem_resp, l1_mem_mem_resp}, 16'd0);
    l1_if_memread = 1'b1;
    l1_if_memaddr = 16'h0010;
    @(negedge clk);
    chk("l1 read resp", {14'd0, l1_if_mem_resp, l1_mem_mem_resp}, 16'd2);
    chk("l1 read data", l1_if_mem_rdata, 16'hBEEF);
    l1_if_memread = 1'b0;
    @(negedge clk);
    chk("l1 read idle", {14'd0, l1_if_mem_resp, l1_mem_mem_resp}, 16'd0);
    chk("l1 mem rdata held", l1_mem_mem_rdata, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
